tiny5_mem_arbiter: RTL and testbench
====================================

// Module: tiny5_mem_arbiter
// PURPOSE
//  Shares one downstream memory port between the IF-stage fetch port (imem, read-only) and the
//  MEM-stage load/store port (dmem). One transaction in flight at a time. Each grant is held
//  until its response returns. Sits between the pipeline and a unified single-ported memory.
// PARAMETERS
//  ADDR_W       32  address width, all ports
//  DATA_W       32  data width, all ports
//  STARVE_LIMIT 4   fixed-priority mode: max consecutive dmem grants while imem waits (>=1)
// PORTS
//  clk_i            in   1       clock
//  reset_n_i        in   1       reset; asynchronous assert, active-low
//  imem_req_valid_i in   1       fetch request
//  imem_req_ready_o out  1       fetch request accepted this cycle
//  imem_addr_i      in   ADDR_W  fetch address, word access
//  imem_rsp_valid_o out  1       fetch data valid; one-cycle pulse, always consumed
//  imem_rsp_data_o  out  DATA_W  fetch data
//  dmem_req_valid_i in   1       load/store request
//  dmem_req_ready_o out  1       load/store accepted this cycle
//  dmem_addr_i      in   ADDR_W  load/store address
//  dmem_we_i        in   1       1 = store, 0 = load
//  dmem_size_i      in   2       mem_access_size_t
//  dmem_wr_data_i   in   DATA_W  store data
//  dmem_rsp_valid_o out  1       load data / store ack; one-cycle pulse
//  dmem_rsp_data_o  out  DATA_W  load data; don't-care for stores
//  mem_req_valid_o  out  1       downstream request
//  mem_req_ready_i  in   1       downstream accepts request
//  mem_addr_o / mem_we_o / mem_size_o / mem_wr_data_o  out  ADDR_W/1/2/DATA_W  latched request
//  mem_rsp_valid_i  in   1       downstream completion; sent for reads and writes
//  mem_rsp_data_i   in   DATA_W  downstream read data
// BEHAVIOUR
//  Reset: state=IDLE. Every output is 0; owner=IMEM, starve_cnt=0, rr_last=DMEM.
//  FSM has three states:
//  - IDLE: pick a winner from the valid requests. Assert only the winner's *_req_ready_o
//    (combinational from the valids). Latch addr/we/size/wr_data (imem: we=0, size=WORD)
//    and the owner. Then go to REQ. No valid request -> stay in IDLE.
//  - REQ: mem_req_valid_o=1 with the latched fields, held stable until mem_req_ready_i.
//    Then go to RESP.
//  - RESP: wait for mem_rsp_valid_i. In that same cycle, pulse the owner's *_rsp_valid_o
//    with data = mem_rsp_data_i (combinational pass-through). Then go to IDLE.
//  Minimum latency: accept at cycle N; mem_req_valid_o at N+1; response pulse at N+2 when the
//  downstream answers with zero wait. Back-to-back transactions cost 3 cycles each.
//  mem_rsp_valid_i in IDLE or REQ is a protocol error: ignore it and flag it with an assertion.
//  Requesters hold valid and payload stable until ready (assertion). The non-winner's ready
//  stays 0, so its request simply waits.
//  Fixed priority (macro off): dmem wins when both are valid. starve_cnt counts +1 per dmem
//  grant made while imem_req_valid_i=1. It clears on any imem grant and saturates at
//  STARVE_LIMIT. At STARVE_LIMIT, imem wins the next tie.
//  reset_n_i low mid-transaction: drop to IDLE at once, all outputs 0. The in-flight
//  transaction is abandoned; the downstream is reset by the same reset.
// CONFIGURATION
//  TINY5_MEM_ARB_RR_EN defined: round-robin. On a tie, the grant goes to the port not granted
//  last (rr_last, updated on every grant). starve_cnt and STARVE_LIMIT are unused.
//  Undefined: fixed dmem priority with the starvation limit above.
// STRUCTURE
//  Add to the definitions package:
//  - enum mem_arb_state_t {ARB_IDLE, ARB_REQ, ARB_RESP}
//  - enum mem_arb_port_t {ARB_PORT_IMEM, ARB_PORT_DMEM}
//  - struct mem_arb_req_t {addr, we, size (mem_access_size_t), wr_data}
//  Reuse mem_access_size_t unchanged.
//  One sub-module: tiny5_mem_arb_picker, combinational. Inputs: both valids, starve_cnt,
//  rr_last. Output: winner. Its RR/fixed selection is under the same macro.
// TESTING
//  1. Only imem valid, addr 0x100, mem ready immediately, rsp 0xDEADBEEF one cycle later
//     -> imem_rsp_valid_o pulses once with 0xDEADBEEF, 2 cycles after accept.
//  2. Both valid same cycle, dmem store 0x200 data 0x55 size BYTE -> dmem granted first;
//     mem_we_o=1, mem_size_o=BYTE. imem granted next cycle it is in IDLE.
//  3. mem_req_ready_i held low 5 cycles -> mem_addr_o/we/size/wr_data unchanged all 5 cycles;
//     no rsp pulse occurs.
//  4. Fixed mode, STARVE_LIMIT=4, dmem and imem valid continuously -> grant order
//     D,D,D,D,I,D,D,D,D,I. RR_EN build -> strictly alternating I/D.
//  5. reset_n_i pulsed low in RESP -> outputs 0 asynchronously; a late mem_rsp_valid_i after
//     release yields no rsp pulse; the next request is served normally.
//  6. Random valid/ready/latency, 10k transactions -> one response per accept, in order,
//     routed to the correct owner; no assertion fires.

Source files
------------

// File: rtl/tiny5_mem_arbiter_pkg.sv
// tiny5 memory arbiter definitions: access sizes, arbiter FSM states,
// requester port ids and the latched downstream request record.
package tiny5_mem_arbiter_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } mem_arb_state_t;

  typedef enum logic {
    ARB_PORT_IMEM,
    ARB_PORT_DMEM
  } mem_arb_port_t;

  // Field widths are the package maxima; narrower ports use the low bits.
  typedef struct packed {
    logic [MEM_ARB_ADDR_W-1:0] addr;
    logic                      we;
    mem_access_size_t          size;
    logic [MEM_ARB_DATA_W-1:0] wr_data;
  } mem_arb_req_t;

  function automatic mem_arb_port_t arb_other_port(input mem_arb_port_t p);
    return (p == ARB_PORT_IMEM) ? ARB_PORT_DMEM : ARB_PORT_IMEM;
  endfunction

endpackage

// File: rtl/tiny5_mem_arbiter_picker.sv
// tiny5_mem_arb_picker: combinational winner selection between imem and dmem.
// TINY5_MEM_ARB_RR_EN defined -> round-robin on ties (rr_last);
// undefined -> dmem priority, imem forced through once starve_cnt hits STARVE_LIMIT.
module tiny5_mem_arb_picker
  import tiny5_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             i_imem_valid,
  input  logic             i_dmem_valid,
  input  logic [CNT_W-1:0] i_starve_cnt,
  input  logic             i_rr_last,
  output logic             o_winner
);

`ifdef TINY5_MEM_ARB_RR_EN
  logic w_unused_cnt;
  assign w_unused_cnt = ^i_starve_cnt;
`else
  logic w_unused_rr;
  assign w_unused_rr = i_rr_last;
`endif

  // Single requester wins outright; ties resolved by the configured policy.
  always_comb begin
    o_winner = ARB_PORT_IMEM;
    if (i_imem_valid && i_dmem_valid) begin
`ifdef TINY5_MEM_ARB_RR_EN
      o_winner = arb_other_port(mem_arb_port_t'(i_rr_last));
`else
      o_winner = (i_starve_cnt >= CNT_W'(STARVE_LIMIT)) ? ARB_PORT_IMEM : ARB_PORT_DMEM;
`endif
    end else if (i_dmem_valid) begin
      o_winner = ARB_PORT_DMEM;
    end
  end

endmodule

// File: rtl/tiny5_mem_arbiter.sv
// tiny5_mem_arbiter: shares one downstream memory port between the fetch (imem)
// and load/store (dmem) ports, one transaction in flight at a time.
// Optional macro TINY5_MEM_ARB_RR_EN selects round-robin instead of dmem
// priority with starvation limit.
module tiny5_mem_arbiter
  import tiny5_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W       = MEM_ARB_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              imem_req_valid_i,
  output logic              imem_req_ready_o,
  input  logic [ADDR_W-1:0] imem_addr_i,
  output logic              imem_rsp_valid_o,
  output logic [DATA_W-1:0] imem_rsp_data_o,
  input  logic              dmem_req_valid_i,
  output logic              dmem_req_ready_o,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic              dmem_we_i,
  input  logic [1:0]        dmem_size_i,
  input  logic [DATA_W-1:0] dmem_wr_data_i,
  output logic              dmem_rsp_valid_o,
  output logic [DATA_W-1:0] dmem_rsp_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_size_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rsp_data_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  mem_arb_state_t   r_state;
  mem_arb_state_t   w_state_nxt;
  mem_arb_port_t    r_owner;
  mem_arb_port_t    r_rr_last;
  logic [CNT_W-1:0] r_starve_cnt;
  mem_arb_req_t     r_req;
  mem_arb_req_t     w_req_sel;
  logic             w_any_valid;
  logic             w_grant;
  logic             w_winner;

  assign w_any_valid = imem_req_valid_i | dmem_req_valid_i;
  assign w_grant     = (r_state == ARB_IDLE) && w_any_valid;

  tiny5_mem_arb_picker #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_picker (
    .i_imem_valid (imem_req_valid_i),
    .i_dmem_valid (dmem_req_valid_i),
    .i_starve_cnt (r_starve_cnt),
    .i_rr_last    (r_rr_last),
    .o_winner     (w_winner)
  );

  // Request record presented by the current winner.
  always_comb begin
    w_req_sel = '0;
    if (w_winner == ARB_PORT_IMEM) begin
      w_req_sel.addr[ADDR_W-1:0] = imem_addr_i;
      w_req_sel.we               = 1'b0;
      w_req_sel.size             = MEM_SIZE_WORD;
    end else begin
      w_req_sel.addr[ADDR_W-1:0]    = dmem_addr_i;
      w_req_sel.we                  = dmem_we_i;
      w_req_sel.size                = mem_access_size_t'(dmem_size_i);
      w_req_sel.wr_data[DATA_W-1:0] = dmem_wr_data_i;
    end
  end

  // Next state and handshake outputs; readies are gated by reset so every
  // output reads 0 while reset is held, even with requests pending.
  always_comb begin
    w_state_nxt      = r_state;
    imem_req_ready_o = 1'b0;
    dmem_req_ready_o = 1'b0;
    mem_req_valid_o  = 1'b0;
    imem_rsp_valid_o = 1'b0;
    dmem_rsp_valid_o = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any_valid && reset_n_i) begin
          w_state_nxt = ARB_REQ;
          if (w_winner == ARB_PORT_IMEM) imem_req_ready_o = 1'b1;
          else                           dmem_req_ready_o = 1'b1;
        end
      end
      ARB_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) w_state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        if (mem_rsp_valid_i) begin
          w_state_nxt = ARB_IDLE;
          if (r_owner == ARB_PORT_IMEM) imem_rsp_valid_o = 1'b1;
          else                          dmem_rsp_valid_o = 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign imem_rsp_data_o = imem_rsp_valid_o ? mem_rsp_data_i : '0;
  assign dmem_rsp_data_o = dmem_rsp_valid_o ? mem_rsp_data_i : '0;

  assign mem_addr_o    = r_req.addr[ADDR_W-1:0];
  assign mem_we_o      = r_req.we;
  assign mem_size_o    = r_req.size;
  assign mem_wr_data_o = r_req.wr_data[DATA_W-1:0];

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ARB_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Latch request and owner on grant; track fairness history.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_req        <= '0;
      r_owner      <= ARB_PORT_IMEM;
      r_rr_last    <= ARB_PORT_DMEM;
      r_starve_cnt <= '0;
    end else if (w_grant) begin
      r_req     <= w_req_sel;
      r_owner   <= mem_arb_port_t'(w_winner);
      r_rr_last <= mem_arb_port_t'(w_winner);
      if (w_winner == ARB_PORT_IMEM) begin
        r_starve_cnt <= '0;
      end else if (imem_req_valid_i && (r_starve_cnt < CNT_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_rsp_only_in_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mem_rsp_valid_i |-> (r_state == ARB_RESP));

  a_imem_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (imem_req_valid_i && !imem_req_ready_o) |=> (imem_req_valid_i && $stable(imem_addr_i)));

  a_dmem_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (dmem_req_valid_i && !dmem_req_ready_o) |=>
      (dmem_req_valid_i && $stable(dmem_addr_i) && $stable(dmem_we_i) &&
       $stable(dmem_size_i) && $stable(dmem_wr_data_i)));
`endif

endmodule

// File: tb/tb_tiny5_mem_arbiter.sv
// Directed bench for tiny5_mem_arbiter: inputs change 1 time unit after the
// rising edge, outputs are sampled mid-cycle.
module tb_tiny5_mem_arbiter;
  import tiny5_mem_arbiter_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        imem_req_valid_i, imem_req_ready_o, imem_rsp_valid_o;
  logic [31:0] imem_addr_i, imem_rsp_data_o;
  logic        dmem_req_valid_i, dmem_req_ready_o, dmem_we_i, dmem_rsp_valid_o;
  logic [1:0]  dmem_size_i;
  logic [31:0] dmem_addr_i, dmem_wr_data_i, dmem_rsp_data_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_rsp_valid_i;
  logic [1:0]  mem_size_o;
  logic [31:0] mem_addr_o, mem_wr_data_o, mem_rsp_data_i;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        exp_seq [10];

  always #5 clk_i = ~clk_i;

  tiny5_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .imem_req_valid_i (imem_req_valid_i),
    .imem_req_ready_o (imem_req_ready_o),
    .imem_addr_i      (imem_addr_i),
    .imem_rsp_valid_o (imem_rsp_valid_o),
    .imem_rsp_data_o  (imem_rsp_data_o),
    .dmem_req_valid_i (dmem_req_valid_i),
    .dmem_req_ready_o (dmem_req_ready_o),
    .dmem_addr_i      (dmem_addr_i),
    .dmem_we_i        (dmem_we_i),
    .dmem_size_i      (dmem_size_i),
    .dmem_wr_data_i   (dmem_wr_data_i),
    .dmem_rsp_valid_o (dmem_rsp_valid_o),
    .dmem_rsp_data_o  (dmem_rsp_data_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_we_o         (mem_we_o),
    .mem_size_o       (mem_size_o),
    .mem_wr_data_o    (mem_wr_data_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i)
  );

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    #4;
  endtask

  // One transaction from the IDLE cycle (requests already driven) until the
  // next IDLE drive point. exp_d: 1 = dmem expected to win.
  task automatic serve(input string tag, input logic exp_d, input logic [31:0] exp_addr,
                       input logic exp_we, input logic [1:0] exp_size, input logic [31:0] exp_wd,
                       input int unsigned rdy_wait, input int unsigned rsp_wait,
                       input logic [31:0] rdata);
    smp();
    chk_eq({tag, ".imem_rdy"}, imem_req_ready_o, !exp_d);
    chk_eq({tag, ".dmem_rdy"}, dmem_req_ready_o, exp_d);
    chk_eq({tag, ".idle_mreq"}, mem_req_valid_o, 1'b0);
    chk_eq({tag, ".idle_rsp"}, {imem_rsp_valid_o, dmem_rsp_valid_o}, 2'b00);
    nxt();
    // Winner drops its request and scrambles its payload: outputs must stay latched.
    if (exp_d) begin
      dmem_req_valid_i = 1'b0;
      dmem_addr_i      = 32'hFFFF_FFF0;
      dmem_we_i        = ~dmem_we_i;
      dmem_size_i      = 2'd3;
      dmem_wr_data_i   = 32'hA5A5_A5A5;
    end else begin
      imem_req_valid_i = 1'b0;
      imem_addr_i      = 32'hFFFF_FFFC;
    end
    for (int i = 0; i <= int'(rdy_wait); i++) begin
      mem_req_ready_i = (i == int'(rdy_wait));
      smp();
      chk_eq($sformatf("%s.mreq%0d", tag, i), mem_req_valid_o, 1'b1);
      chk_eq($sformatf("%s.addr%0d", tag, i), mem_addr_o, exp_addr);
      chk_eq($sformatf("%s.we%0d", tag, i), mem_we_o, exp_we);
      chk_eq($sformatf("%s.size%0d", tag, i), mem_size_o, exp_size);
      if (exp_we) chk_eq($sformatf("%s.wd%0d", tag, i), mem_wr_data_o, exp_wd);
      chk_eq($sformatf("%s.rspq%0d", tag, i), {imem_rsp_valid_o, dmem_rsp_valid_o}, 2'b00);
      nxt();
    end
    mem_req_ready_i = 1'b0;
    for (int i = 0; i <= int'(rsp_wait); i++) begin
      mem_rsp_valid_i = (i == int'(rsp_wait));
      mem_rsp_data_i  = (i == int'(rsp_wait)) ? rdata : (32'hBAD0_0000 | i);
      smp();
      chk_eq($sformatf("%s.resp_mreq%0d", tag, i), mem_req_valid_o, 1'b0);
      chk_eq($sformatf("%s.irsp%0d", tag, i), imem_rsp_valid_o, (i == int'(rsp_wait)) && !exp_d);
      chk_eq($sformatf("%s.drsp%0d", tag, i), dmem_rsp_valid_o, (i == int'(rsp_wait)) && exp_d);
      if (i == int'(rsp_wait) && !exp_we) begin
        if (exp_d) chk_eq({tag, ".ddata"}, dmem_rsp_data_o, rdata);
        else       chk_eq({tag, ".idata"}, imem_rsp_data_o, rdata);
      end
      nxt();
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
  endtask

  initial begin
`ifdef TINY5_MEM_ARB_RR_EN
    for (int k = 0; k < 10; k++) exp_seq[k] = (k % 2 == 1);
`else
    for (int k = 0; k < 10; k++) exp_seq[k] = !(k == 4 || k == 9);
`endif

    // Reset with requests pending: every output must read 0.
    reset_n_i        = 1'b0;
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h0000_0100;
    dmem_req_valid_i = 1'b1;
    dmem_addr_i      = 32'h0000_0200;
    dmem_we_i        = 1'b1;
    dmem_size_i      = MEM_SIZE_BYTE;
    dmem_wr_data_i   = 32'h55;
    mem_req_ready_i  = 1'b0;
    mem_rsp_valid_i  = 1'b0;
    mem_rsp_data_i   = '0;
    #2;
    chk_eq("rst.imem_rdy", imem_req_ready_o, 1'b0);
    chk_eq("rst.dmem_rdy", dmem_req_ready_o, 1'b0);
    chk_eq("rst.mreq", mem_req_valid_o, 1'b0);
    chk_eq("rst.addr", mem_addr_o, 32'h0);
    chk_eq("rst.rsp", {imem_rsp_valid_o, dmem_rsp_valid_o}, 2'b00);
    imem_req_valid_i = 1'b0;
    dmem_req_valid_i = 1'b0;
    nxt();
    nxt();
    reset_n_i = 1'b1;
    nxt();

    // 1: lone fetch, zero-wait downstream.
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h0000_0100;
    serve("t1", 1'b0, 32'h100, 1'b0, MEM_SIZE_WORD, 32'h0, 0, 0, 32'hDEAD_BEEF);

    // 2: simultaneous requests, dmem store wins, fetch follows.
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h0000_0104;
    dmem_req_valid_i = 1'b1;
    dmem_addr_i      = 32'h0000_0200;
    dmem_we_i        = 1'b1;
    dmem_size_i      = MEM_SIZE_BYTE;
    dmem_wr_data_i   = 32'h55;
    serve("t2d", 1'b1, 32'h200, 1'b1, MEM_SIZE_BYTE, 32'h55, 0, 0, 32'h0);
    serve("t2i", 1'b0, 32'h104, 1'b0, MEM_SIZE_WORD, 32'h0, 0, 0, 32'h1111_2222);

    // 3: downstream stalls the request 5 cycles, then a slow response.
    dmem_req_valid_i = 1'b1;
    dmem_addr_i      = 32'h0000_0300;
    dmem_we_i        = 1'b0;
    dmem_size_i      = MEM_SIZE_HALF;
    dmem_wr_data_i   = 32'h0;
    serve("t3", 1'b1, 32'h300, 1'b0, MEM_SIZE_HALF, 32'h0, 5, 2, 32'h1234_5678);

    // 4: both ports saturated; grant order shows the fairness policy.
    for (int k = 0; k < 10; k++) begin
      imem_req_valid_i = 1'b1;
      imem_addr_i      = 32'h0000_0400;
      dmem_req_valid_i = 1'b1;
      dmem_addr_i      = 32'h0000_0500;
      dmem_we_i        = 1'b0;
      dmem_size_i      = MEM_SIZE_WORD;
      dmem_wr_data_i   = 32'h0;
      serve($sformatf("t4.%0d", k), exp_seq[k], exp_seq[k] ? 32'h500 : 32'h400, 1'b0,
            MEM_SIZE_WORD, 32'h0, 0, 0, 32'hA000 + k);
    end
    // Serve whichever port was left waiting.
    imem_req_valid_i = exp_seq[9];
    imem_addr_i      = 32'h0000_0400;
    dmem_req_valid_i = !exp_seq[9];
    dmem_addr_i      = 32'h0000_0500;
    dmem_we_i        = 1'b0;
    dmem_size_i      = MEM_SIZE_WORD;
    serve("t4.drain", !exp_seq[9], exp_seq[9] ? 32'h400 : 32'h500, 1'b0, MEM_SIZE_WORD,
          32'h0, 0, 0, 32'hB0B0);

    // 5: reset asserted while waiting for the response.
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h0000_0600;
    smp();
    chk_eq("t5.rdy", imem_req_ready_o, 1'b1);
    nxt();
    imem_req_valid_i = 1'b0;
    mem_req_ready_i  = 1'b1;
    smp();
    chk_eq("t5.mreq", mem_req_valid_o, 1'b1);
    nxt();
    mem_req_ready_i = 1'b0;
    smp();
    chk_eq("t5.in_resp", {mem_req_valid_o, imem_rsp_valid_o}, 2'b00);
    chk_eq("t5.addr_pre", mem_addr_o, 32'h600);
    reset_n_i        = 1'b0;
    imem_req_valid_i = 1'b1;
    dmem_req_valid_i = 1'b1;
    #1;
    chk_eq("t5.async_addr", mem_addr_o, 32'h0);
    chk_eq("t5.async_rdy", {imem_req_ready_o, dmem_req_ready_o}, 2'b00);
    chk_eq("t5.async_mreq", mem_req_valid_o, 1'b0);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hCAFE_F00D;
    #1;
    chk_eq("t5.late_rsp", {imem_rsp_valid_o, dmem_rsp_valid_o}, 2'b00);
    chk_eq("t5.late_data", imem_rsp_data_o, 32'h0);
    nxt();
    smp();
    chk_eq("t5.held_rst", {mem_req_valid_o, imem_rsp_valid_o, imem_req_ready_o}, 3'b000);
    nxt();
    mem_rsp_valid_i  = 1'b0;
    mem_rsp_data_i   = '0;
    imem_req_valid_i = 1'b0;
    dmem_req_valid_i = 1'b0;
    reset_n_i        = 1'b1;
    smp();
    chk_eq("t5.post_rel", {mem_req_valid_o, imem_rsp_valid_o, dmem_rsp_valid_o}, 3'b000);
    nxt();
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h0000_0700;
    serve("t5.next", 1'b0, 32'h700, 1'b0, MEM_SIZE_WORD, 32'h0, 1, 1, 32'h0BAD_F00D);

    // 6: alternating owners with varying request and response latency.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        imem_req_valid_i = 1'b1;
        imem_addr_i      = 32'h0000_1000 + 32'(k * 4);
        serve($sformatf("t6.%0d", k), 1'b0, 32'h1000 + 32'(k * 4), 1'b0, MEM_SIZE_WORD,
              32'h0, k % 3, (k + 1) % 3, 32'h6000_0000 + k);
      end else begin
        dmem_req_valid_i = 1'b1;
        dmem_addr_i      = 32'h0000_2000 + 32'(k * 4);
        dmem_we_i        = (k == 3);
        dmem_size_i      = MEM_SIZE_HALF;
        dmem_wr_data_i   = 32'h7700 + k;
        serve($sformatf("t6.%0d", k), 1'b1, 32'h2000 + 32'(k * 4), k == 3, MEM_SIZE_HALF,
              32'h7700 + k, k % 3, (k + 1) % 3, 32'h6000_0000 + k);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
